// File: rtl/hello_scroll_monitor.sv
// hello_scroll_monitor
//   Receive-side checker for the 8-digit "HELLO" scroller. Decodes the eight
//   active-low 7-segment buses back to letter codes. Finds which rotation of
//   "   HELLO" is on display. Tracks the rotation offset frame to frame to
//   confirm a clean one-step left scroll.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous active-low reset
//   sample     in   1      capture HEX0..HEX7 on this edge
//   HEX0..HEX7 in   [0:6]  segments a..g, active-low; HEX7 is the leftmost digit
//   codes      out  24     decoded letters, [3i+2:3i] belongs to digit i
//   offset     out  3      rotation offset of the last matching frame
//   frame_ok   out  1      the last sampled frame matched a rotation
//   locked     out  1      high while in LOCKED
//   step_err   out  1      one-cycle pulse when a lock is lost
//   err_cnt    out  CNT_W  saturating count of step_err pulses
//   wrap_cnt   out  CNT_W  saturating count of 7->0 steps while LOCKED
module hello_scroll_monitor #(
  parameter int LOCK_STEPS = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample,
  input  logic [0:6]       HEX0,
  input  logic [0:6]       HEX1,
  input  logic [0:6]       HEX2,
  input  logic [0:6]       HEX3,
  input  logic [0:6]       HEX4,
  input  logic [0:6]       HEX5,
  input  logic [0:6]       HEX6,
  input  logic [0:6]       HEX7,
  output logic [23:0]      codes,
  output logic [2:0]       offset,
  output logic             frame_ok,
  output logic             locked,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  // Segment pattern (a..g, active-low) to letter code; 100 marks invalid.
  function automatic logic [2:0] seg_decode(input logic [0:6] seg);
    case (seg)
      7'b1001000: return 3'b000;  // H
      7'b0110000: return 3'b001;  // E
      7'b1110001: return 3'b010;  // L
      7'b0000001: return 3'b011;  // O
      7'b1111111: return 3'b111;  // blank
      default:    return 3'b100;
    endcase
  endfunction

  // Reference string B,B,B,H,E,L,L,O indexed 0..7.
  function automatic logic [2:0] ref_code(input logic [2:0] idx);
    case (idx)
      3'd3:       return 3'b000;
      3'd4:       return 3'b001;
      3'd5, 3'd6: return 3'b010;
      3'd7:       return 3'b011;
      default:    return 3'b111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [23:0]      codes_q, codes_d;
  logic [2:0]       offset_q, offset_d;
  logic             frame_ok_q, frame_ok_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [2:0]       good_q, good_d;

  logic [0:6] hex_bus [8];
  logic [2:0] dig [8];
  logic       match_any;
  logic [2:0] match_k;
  logic       hit;
  logic [2:0] prev_plus;
  logic       is_step;
  logic       is_same;

  always_comb begin
    hex_bus[0] = HEX0;
    hex_bus[1] = HEX1;
    hex_bus[2] = HEX2;
    hex_bus[3] = HEX3;
    hex_bus[4] = HEX4;
    hex_bus[5] = HEX5;
    hex_bus[6] = HEX6;
    hex_bus[7] = HEX7;
    for (int i = 0; i < 8; i++) begin
      dig[i] = seg_decode(hex_bus[i]);
    end
  end

  // Try every rotation; an invalid digit (100) never equals a reference code,
  // so it blocks all matches. Rotations of the string are all distinct, so at
  // most one k hits.
  always_comb begin
    match_any = 1'b0;
    match_k   = 3'd0;
    hit       = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hit = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (dig[7-i] != ref_code(3'(i + k))) hit = 1'b0;
      end
      if (hit) begin
        match_any = 1'b1;
        match_k   = 3'(k);
      end
    end
  end

  assign prev_plus = offset_q + 3'd1;
  assign is_step   = (match_k == prev_plus);
  assign is_same   = (match_k == offset_q);

  always_comb begin
    state_d    = state_q;
    codes_d    = codes_q;
    offset_d   = offset_q;
    frame_ok_d = frame_ok_q;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    good_d     = good_q;

    if (sample) begin
      codes_d    = {dig[7], dig[6], dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
      frame_ok_d = match_any;
      if (match_any) offset_d = match_k;

      case (state_q)
        SEARCH: begin
          if (match_any) begin
            good_d  = 3'd0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!match_any) begin
            state_d = SEARCH;
          end else if (is_step) begin
            good_d = good_q + 3'd1;
            if ((int'(good_q) + 1) >= LOCK_STEPS) state_d = LOCKED;
          end else if (!is_same) begin
            good_d = 3'd0;
          end
        end
        LOCKED: begin
          if (!match_any) begin
            step_err_d = 1'b1;
            err_cnt_d  = sat_inc(err_cnt_q);
            state_d    = SEARCH;
          end else if (is_step) begin
            if (offset_q == 3'd7) wrap_cnt_d = sat_inc(wrap_cnt_q);
          end else if (!is_same) begin
            step_err_d = 1'b1;
            err_cnt_d  = sat_inc(err_cnt_q);
            good_d     = 3'd0;
            state_d    = ACQUIRE;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= SEARCH;
      codes_q    <= 24'hFFFFFF;
      offset_q   <= 3'd0;
      frame_ok_q <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      good_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      codes_q    <= codes_d;
      offset_q   <= offset_d;
      frame_ok_q <= frame_ok_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      good_q     <= good_d;
    end
  end

  assign codes    = codes_q;
  assign offset   = offset_q;
  assign frame_ok = frame_ok_q;
  assign locked   = (state_q == LOCKED);
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule
